// File: rtl/mmio_uart_transmitter.sv
// MMIO byte console: buffers CPU stores in a FIFO and shifts them out as 8N1 UART, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1, 11-bit frame).
module mmio_uart_transmitter #(
  parameter int CLOCKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_strobe,
  input  logic [7:0] write_data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int PTR_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO   = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  logic [7:0]        mem_r [0:DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  state_t            state_r, state_next_s;
  logic [BAUD_W-1:0] baud_r, baud_next_s;
  logic [2:0]        bit_r, bit_next_s;
  logic [7:0]        shift_r, shift_next_s;
  logic              full_r, empty_r, busy_r, overflow_r, tx_r;
  logic              wr_en_s, pop_s, full_next_s, empty_next_s, busy_next_s, tx_next_s;
  logic [7:0]        head_s;
`ifdef UART_TX_PARITY_EN
  logic              parity_r, parity_next_s;
`endif

  // Full is taken from the registered flag so a same-cycle pop never frees room for a strobe.
  assign wr_en_s = write_strobe & ~full_r;
  assign head_s  = mem_r[rd_ptr_r[FIFO_DEPTH_LOG2-1:0]];

  // Frame sequencer: next state, baud/bit counters, shift register and pop request.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    pop_s        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next_s = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_r) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
          baud_next_s  = BAUD_RELOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_ZERO) begin
          state_next_s = ST_DATA;
          bit_next_s   = 3'd0;
          baud_next_s  = BAUD_RELOAD;
        end else begin
          baud_next_s = baud_r - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_ZERO) begin
          baud_next_s  = BAUD_RELOAD;
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r - BAUD_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_r == BAUD_ZERO) begin
          state_next_s = ST_STOP;
          baud_next_s  = BAUD_RELOAD;
        end else begin
          baud_next_s = baud_r - BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (baud_r == BAUD_ZERO) begin
          baud_next_s = BAUD_RELOAD;
          if (!empty_r) begin
            pop_s        = 1'b1;
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          baud_next_s = baud_r - BAUD_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        baud_next_s  = BAUD_ZERO;
      end
    endcase
    if (pop_s) begin
      shift_next_s = head_s;
`ifdef UART_TX_PARITY_EN
      parity_next_s = even_parity(head_s);
`endif
    end else begin
      shift_next_s = shift_next_s;
    end
  end

  // Pointer updates, status flags and the line level, all derived from next-cycle values.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    tx_next_s     = 1'b1;
    if (wr_en_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    empty_next_s = (wr_ptr_next_s == rd_ptr_next_s);
    full_next_s  = (wr_ptr_next_s[PTR_W-1] != rd_ptr_next_s[PTR_W-1]) &&
                   (wr_ptr_next_s[PTR_W-2:0] == rd_ptr_next_s[PTR_W-2:0]);
    busy_next_s  = (state_next_s != ST_IDLE) | ~empty_next_s;
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next_s = parity_next_s;
`endif
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // State and status registers; reset drives the line idle without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      baud_r     <= BAUD_ZERO;
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_next_s;
      baud_r     <= baud_next_s;
      bit_r      <= bit_next_s;
      shift_r    <= shift_next_s;
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      full_r     <= full_next_s;
      empty_r    <= empty_next_s;
      busy_r     <= busy_next_s;
      overflow_r <= overflow_r | (write_strobe & full_r);
      tx_r       <= tx_next_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_next_s;
`endif
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[FIFO_DEPTH_LOG2-1:0]] <= write_data;
    end
  end

  assign fifo_full  = full_r;
  assign fifo_empty = empty_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign tx         = tx_r;

endmodule

// File: tb/tb_mmio_uart_transmitter.sv
// Bench for mmio_uart_transmitter: cycle-exact frame table, a line monitor feeding a byte scoreboard,
// and hand sequences for back-to-back frames, overflow and asynchronous reset.
module tb_mmio_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       fifo_full, fifo_empty, busy, overflow, tx;

  mmio_uart_transmitter #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .write_strobe(write_strobe), .write_data(write_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .busy(busy), .overflow(overflow), .tx(tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  int starts[$];
  int frames_seen = 0;
  int cyc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decodes frames on tx, checks bit widths, pops the scoreboard.
  bit         mon_active = 1'b0;
  int         mon_idx, mon_b, mon_w;
  bit         mon_shape_ok;
  logic [7:0] mon_byte;
  logic       mon_pbit;
  always @(negedge clk) begin
    cyc_cnt++;
    if (!reset_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_idx = 1;
        mon_shape_ok = 1'b1;
        mon_byte = 8'h00;
        mon_pbit = 1'b0;
        starts.push_back(cyc_cnt);
      end
    end else begin
      mon_b = mon_idx / CPB;
      mon_w = mon_idx % CPB;
      if (mon_b == 0) begin
        if (tx !== 1'b0) mon_shape_ok = 1'b0;
      end else if (mon_b <= 8) begin
        if (mon_w == 0) mon_byte[mon_b-1] = tx;
        else if (tx !== mon_byte[mon_b-1]) mon_shape_ok = 1'b0;
`ifdef UART_TX_PARITY_EN
      end else if (mon_b == 9) begin
        if (mon_w == 0) mon_pbit = tx;
        else if (tx !== mon_pbit) mon_shape_ok = 1'b0;
`endif
      end else begin
        if (tx !== 1'b1) mon_shape_ok = 1'b0;
      end
      mon_idx++;
      if (mon_idx == FRAME_CYC) begin
        mon_active = 1'b0;
        frames_seen++;
        check("mon_shape", mon_shape_ok, 1);
`ifdef UART_TX_PARITY_EN
        check("mon_parity", mon_pbit, ^mon_byte);
`endif
        check("mon_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) check("mon_byte", mon_byte, sb.pop_front());
      end
    end
  end

  // Called at posedge+1; strobe is sampled on the following edge.
  task automatic drive_write(input logic [7:0] d, input bit expect_sent);
    write_strobe = 1'b1;
    write_data = d;
    if (expect_sent) sb.push_back(d);
    @(posedge clk); #1;
    write_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    check("wait_idle", done, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // frame[i] is the i-th bit on the line
  } vec_t;
  vec_t vecs[5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   f0, idle_err, gap;
    logic exp_b;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};
    vecs[1] = '{8'h03, {1'b1, 1'b0, 8'h03, 1'b0}};
    vecs[2] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}};
    vecs[3] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
    vecs[4] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}};
`else
    vecs[0] = '{8'h55, {1'b0, 1'b1, 8'h55, 1'b0}};
    vecs[1] = '{8'h00, {1'b0, 1'b1, 8'h00, 1'b0}};
    vecs[2] = '{8'hFF, {1'b0, 1'b1, 8'hFF, 1'b0}};
    vecs[3] = '{8'h81, {1'b0, 1'b1, 8'h81, 1'b0}};
    vecs[4] = '{8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}};
`endif

    // Reset held for 3 cycles, then 20 quiet cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {tx, fifo_empty, fifo_full, busy, overflow}, 5'b11000);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_quiet", {tx, fifo_empty, fifo_full, busy, overflow}, 5'b11000);
    end
    @(posedge clk); #1;

    // Single frames, cycle-exact against the table.
    foreach (vecs[i]) begin
      drive_write(vecs[i].data, 1'b1);
      check($sformatf("v%0d_busy_rise", i), busy, 1);
      check($sformatf("v%0d_not_empty", i), fifo_empty, 0);
      check($sformatf("v%0d_tx_idle", i), tx, 1);
      @(posedge clk);
      for (int c = 0; c < FRAME_CYC; c++) begin
        @(negedge clk);
        exp_b = vecs[i].frame[c / CPB];
        check($sformatf("v%0d_tx_c%0d", i, c), tx, exp_b);
      end
      check($sformatf("v%0d_busy_stop", i), busy, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_busy_fall", i), {busy, tx, fifo_empty}, 3'b011);
      @(posedge clk); #1;
    end

    // Back-to-back frames leave no idle cycle.
    starts.delete();
    drive_write(8'hA5, 1'b1);
    drive_write(8'h3C, 1'b1);
    wait_idle(300);
    check("b2b_frames", starts.size(), 2);
    gap = (starts.size() >= 2) ? (starts[1] - starts[0]) : -1;
    check("b2b_gap", gap, FRAME_CYC);

    // 18 strobes: the 17th fills the FIFO, the 18th is dropped.
    f0 = frames_seen;
    for (int i = 0; i < 18; i++) begin
      drive_write(i[7:0], (i < 17));
      check($sformatf("ovf_full_%0d", i), fifo_full, (i >= 16));
      check($sformatf("ovf_flag_%0d", i), overflow, (i == 17));
    end
    wait_idle(2000);
    check("ovf_frames", frames_seen - f0, 17);
    check("ovf_sb_drained", sb.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    drive_write(8'h0F, 1'b1);
    drive_write(8'h11, 1'b1);
    drive_write(8'h22, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    check("rst_mid_queued", {fifo_empty, busy}, 2'b01);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_async", {tx, fifo_empty, fifo_full, busy, overflow}, 5'b11000);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    f0 = frames_seen;
    idle_err = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1) idle_err++;
    end
    check("rst_mid_no_frames", frames_seen - f0, 0);
    check("rst_mid_idle", idle_err, 0);
    @(posedge clk); #1;

    // Reset during a start bit must raise tx without a clock edge.
    drive_write(8'h81, 1'b1);
    @(posedge clk); #1;
    check("rst_start_low", tx, 0);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_start_async", tx, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_start_after", {tx, busy}, 2'b10);

    check("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
